// File: rtl/ps2_cmd_scheduler.sv
// PS/2 set-2 scan-code parser feeding a 4-entry command FIFO that is
// drained one command per frameStart (vertical blank).
// Optional feature: define CMD_AUTOREPEAT_EN to re-enqueue a held direction
// key (cmd 7..A) every REPEAT_FRAMES frames.
module ps2_cmd_scheduler #(
  parameter int unsigned REPEAT_FRAMES = 15,
  parameter logic [7:0]  IDLE_CODE     = 8'hFF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] scanCode,
  input  logic       scanValid,
  input  logic       frameStart,
  output logic [7:0] cmdCode,
  output logic       cmdValid,
  output logic       overflow,
  output logic [2:0] qCount
);

  typedef enum logic [1:0] {StIdle, StBrk, StExt, StExtBrk} state_e;

  state_e state_q, state_d;
  logic   make_fire;
  logic   scan_ext;
  logic   map_hit;
  logic [3:0] map_cmd;
  logic   scan_push;
  logic   push_req;
  logic [3:0] push_cmd;

  logic [3:0] mem_q [4];
  logic [1:0] rd_ptr_q, wr_ptr_q;
  logic [2:0] count_q;
  logic [7:0] cmd_code_q;
  logic       cmd_valid_q;
  logic       overflow_q;
  logic       pop, do_push, drop;

  // Returns {hit, cmd} for a scan byte, extended or not.
  function automatic logic [4:0] map_code(input logic [7:0] code, input logic ext);
    logic [4:0] r;
    r = 5'h00;
    if (!ext) begin
      case (code)
        8'h45: r = {1'b1, 4'h0};
        8'h16: r = {1'b1, 4'h1};
        8'h1E: r = {1'b1, 4'h2};
        8'h26: r = {1'b1, 4'h3};
        8'h2D: r = {1'b1, 4'h4};
        8'h34: r = {1'b1, 4'h5};
        8'h32: r = {1'b1, 4'h6};
        8'h79: r = {1'b1, 4'hB};
        8'h7B: r = {1'b1, 4'hC};
        8'h2B: r = {1'b1, 4'hD};
        default: r = 5'h00;
      endcase
    end else begin
      case (code)
        8'h75: r = {1'b1, 4'h7};
        8'h72: r = {1'b1, 4'h8};
        8'h6B: r = {1'b1, 4'h9};
        8'h74: r = {1'b1, 4'hA};
        default: r = 5'h00;
      endcase
    end
    return r;
  endfunction

  // Parser next-state and make detection; advances only on scanValid.
  always_comb begin
    state_d   = state_q;
    make_fire = 1'b0;
    if (scanValid) begin
      unique case (state_q)
        StIdle: begin
          if (scanCode == 8'hF0)      state_d = StBrk;
          else if (scanCode == 8'hE0) state_d = StExt;
          else                        make_fire = 1'b1;
        end
        StExt: begin
          if (scanCode == 8'hF0) state_d = StExtBrk;
          else begin
            make_fire = 1'b1;
            state_d   = StIdle;
          end
        end
        StBrk, StExtBrk: state_d = StIdle;
      endcase
    end
  end

  assign scan_ext             = (state_q == StExt) || (state_q == StExtBrk);
  assign {map_hit, map_cmd}   = map_code(scanCode, scan_ext);
  assign scan_push            = make_fire & map_hit;

  // Parser state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

`ifdef CMD_AUTOREPEAT_EN
  localparam int unsigned CntW = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;

  logic            held_valid_q;
  logic [3:0]      held_cmd_q;
  logic [CntW-1:0] rep_cnt_q;
  logic            dir_key;
  logic            brk_fire;
  logic            rep_push;

  assign dir_key  = map_hit && scan_ext && (map_cmd >= 4'h7) && (map_cmd <= 4'hA);
  assign brk_fire = scanValid && ((state_q == StBrk) || (state_q == StExtBrk));
  // A scan-driven push wins over a repeat landing in the same cycle.
  assign rep_push = held_valid_q && frameStart && (rep_cnt_q == '0) && !scan_push;
  assign push_req = scan_push | rep_push;
  assign push_cmd = scan_push ? map_cmd : held_cmd_q;

  // Held-key tracking; counter at zero means the next frame repeats.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      held_valid_q <= 1'b0;
      held_cmd_q   <= 4'h0;
      rep_cnt_q    <= '0;
    end else if (make_fire && dir_key) begin
      held_valid_q <= 1'b1;
      held_cmd_q   <= map_cmd;
      rep_cnt_q    <= '0;
    end else if (brk_fire && dir_key && (map_cmd == held_cmd_q)) begin
      held_valid_q <= 1'b0;
      rep_cnt_q    <= '0;
    end else if (held_valid_q && frameStart) begin
      if (rep_cnt_q == '0) rep_cnt_q <= CntW'(REPEAT_FRAMES - 1);
      else                 rep_cnt_q <= rep_cnt_q - 1'b1;
    end
  end
`else
  assign push_req = scan_push;
  assign push_cmd = map_cmd;
`endif

  assign pop     = frameStart && (count_q != 3'd0);
  assign do_push = push_req && ((count_q != 3'd4) || pop);
  assign drop    = push_req && (count_q == 3'd4) && !pop;

  // FIFO storage, pointers, occupancy, issued command and sticky overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= 4'h0;
      rd_ptr_q    <= 2'd0;
      wr_ptr_q    <= 2'd0;
      count_q     <= 3'd0;
      cmd_code_q  <= IDLE_CODE;
      cmd_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_cmd;
        wr_ptr_q        <= wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q    <= rd_ptr_q + 2'd1;
        cmd_code_q  <= {4'h0, mem_q[rd_ptr_q]};
        cmd_valid_q <= 1'b1;
      end else begin
        cmd_code_q  <= IDLE_CODE;
        cmd_valid_q <= 1'b0;
      end
      count_q <= count_q + {2'b00, do_push} - {2'b00, pop};
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign cmdCode  = cmd_code_q;
  assign cmdValid = cmd_valid_q;
  assign overflow = overflow_q;
  assign qCount   = count_q;

endmodule

// File: tb/tb_ps2_cmd_scheduler.sv
// Self-checking bench for ps2_cmd_scheduler: directed scenarios plus a
// randomized run checked against a queue-based reference model.
module tb_ps2_cmd_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] scanCode = 8'h00;
  logic       scanValid = 1'b0;
  logic       frameStart = 1'b0;
  logic [7:0] cmdCode;
  logic       cmdValid;
  logic       overflow;
  logic [2:0] qCount;

  int checks = 0;
  int errors = 0;

`ifdef CMD_AUTOREPEAT_EN
  ps2_cmd_scheduler #(.REPEAT_FRAMES(2), .IDLE_CODE(8'hFF)) dut (
`else
  ps2_cmd_scheduler #(.IDLE_CODE(8'hFF)) dut (
`endif
    .clock      (clock),
    .reset      (reset),
    .scanCode   (scanCode),
    .scanValid  (scanValid),
    .frameStart (frameStart),
    .cmdCode    (cmdCode),
    .cmdValid   (cmdValid),
    .overflow   (overflow),
    .qCount     (qCount)
  );

  always #5 clock = ~clock;

  // Reference model: pending prefix bytes, command queue, expected outputs.
  int         mk [int];
  logic [7:0] pend [$];
  int         exp_q [$];
  logic [7:0] exp_code = 8'hFF;
  logic       exp_valid = 1'b0;
  logic       exp_ovf = 1'b0;

  task automatic model_clear();
    pend.delete();
    exp_q.delete();
    exp_code  = 8'hFF;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] code);
    logic ext, brk;
    int key;
    if (code == 8'hE0 && pend.size() == 0) pend.push_back(code);
    else if (code == 8'hF0 && (pend.size() == 0 || (pend.size() == 1 && pend[0] == 8'hE0)))
      pend.push_back(code);
    else begin
      ext = (pend.size() > 0 && pend[0] == 8'hE0);
      brk = 1'b0;
      foreach (pend[i]) if (pend[i] == 8'hF0) brk = 1'b1;
      key = (ext ? 256 : 0) + int'(code);
      if (!brk && mk.exists(key)) begin
        if (exp_q.size() < 4) exp_q.push_back(mk[key]);
        else exp_ovf = 1'b1;
      end
      pend.delete();
    end
  endtask

  // One clock cycle of stimulus; model advances at the edge; returns at negedge.
  task automatic cyc(input logic [7:0] code, input logic v, input logic f);
    scanCode = code; scanValid = v; frameStart = f;
    @(posedge clock);
    exp_valid = 1'b0;
    exp_code  = 8'hFF;
    if (f && exp_q.size() > 0) begin
      exp_code  = 8'(exp_q.pop_front());
      exp_valid = 1'b1;
    end
    if (v) model_byte(code);
    #1;
    scanValid = 1'b0; frameStart = 1'b0;
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks++; if (cmdCode !== 8'hFF) begin errors++; $display("FAIL reset_code got %h want ff", cmdCode); end
    checks++; if (cmdValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", cmdValid); end
    checks++; if (qCount !== 3'd0) begin errors++; $display("FAIL reset_qcount got %0d want 0", qCount); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_single_make();
    do_reset();
    cyc(8'h2D, 1'b1, 1'b0);
    checks++; if (qCount !== 3'd1) begin errors++; $display("FAIL single_qcount got %0d want 1", qCount); end
    cyc(8'h00, 1'b0, 1'b1);
    checks++; if (cmdValid !== 1'b1 || cmdCode !== 8'h04) begin
      errors++; $display("FAIL single_issue got %b/%h want 1/04", cmdValid, cmdCode); end
    cyc(8'h00, 1'b0, 1'b0);
    checks++; if (cmdValid !== 1'b0 || cmdCode !== 8'hFF) begin
      errors++; $display("FAIL single_oneshot got %b/%h want 0/ff", cmdValid, cmdCode); end
  endtask

  task automatic test_ext_break();
    do_reset();
    cyc(8'hE0, 1'b1, 1'b0); cyc(8'h75, 1'b1, 1'b0);
    cyc(8'hE0, 1'b1, 1'b0); cyc(8'hF0, 1'b1, 1'b0); cyc(8'h75, 1'b1, 1'b0);
    checks++; if (qCount !== 3'd1) begin errors++; $display("FAIL ext_qcount got %0d want 1", qCount); end
    cyc(8'h00, 1'b0, 1'b1);
    checks++; if (cmdValid !== 1'b1 || cmdCode !== 8'h07) begin
      errors++; $display("FAIL ext_frame1 got %b/%h want 1/07", cmdValid, cmdCode); end
    cyc(8'h00, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b1);
    checks++; if (cmdValid !== 1'b0 || cmdCode !== 8'hFF) begin
      errors++; $display("FAIL ext_frame2 got %b/%h want 0/ff", cmdValid, cmdCode); end
  endtask

  task automatic test_overflow();
    logic [7:0] want [4];
    want[0] = 8'h01; want[1] = 8'h02; want[2] = 8'h03; want[3] = 8'h05;
    do_reset();
    cyc(8'h16, 1'b1, 1'b0); cyc(8'h1E, 1'b1, 1'b0); cyc(8'h26, 1'b1, 1'b0);
    cyc(8'h34, 1'b1, 1'b0);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", overflow); end
    cyc(8'h32, 1'b1, 1'b0);
    checks++; if (overflow !== 1'b1 || qCount !== 3'd4) begin
      errors++; $display("FAIL ovf_full got %b/%0d want 1/4", overflow, qCount); end
    for (int i = 0; i < 4; i++) begin
      cyc(8'h00, 1'b0, 1'b1);
      checks++; if (cmdValid !== 1'b1 || cmdCode !== want[i]) begin
        errors++; $display("FAIL ovf_drain%0d got %b/%h want 1/%h", i, cmdValid, cmdCode, want[i]); end
      cyc(8'h00, 1'b0, 1'b0);
    end
    checks++; if (qCount !== 3'd0 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky got %0d/%b want 0/1", qCount, overflow); end
  endtask

  task automatic test_push_pop_full();
    do_reset();
    cyc(8'h16, 1'b1, 1'b0); cyc(8'h1E, 1'b1, 1'b0); cyc(8'h26, 1'b1, 1'b0);
    cyc(8'h34, 1'b1, 1'b0);
    cyc(8'h2B, 1'b1, 1'b1);
    checks++; if (cmdValid !== 1'b1 || cmdCode !== 8'h01) begin
      errors++; $display("FAIL pp_issue got %b/%h want 1/01", cmdValid, cmdCode); end
    checks++; if (qCount !== 3'd4 || overflow !== 1'b0) begin
      errors++; $display("FAIL pp_state got %0d/%b want 4/0", qCount, overflow); end
    for (int i = 0; i < 4; i++) cyc(8'h00, 1'b0, 1'b1);
    checks++; if (cmdCode !== 8'h0D) begin errors++; $display("FAIL pp_last got %h want 0d", cmdCode); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc(8'hE0, 1'b1, 1'b0);
    do_reset();
    cyc(8'h6B, 1'b1, 1'b0);
    checks++; if (qCount !== 3'd0) begin errors++; $display("FAIL midrst_qcount got %0d want 0", qCount); end
    cyc(8'h00, 1'b0, 1'b1);
    checks++; if (cmdValid !== 1'b0) begin errors++; $display("FAIL midrst_issue got %b want 0", cmdValid); end
  endtask

  task automatic test_typematic();
    do_reset();
    cyc(8'h2D, 1'b1, 1'b0); cyc(8'h2D, 1'b1, 1'b0);
    checks++; if (qCount !== 3'd2) begin errors++; $display("FAIL typematic got %0d want 2", qCount); end
  endtask

`ifdef CMD_AUTOREPEAT_EN
  task automatic test_autorepeat();
    logic want;
    do_reset();
    cyc(8'hE0, 1'b1, 1'b0); cyc(8'h6B, 1'b1, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      cyc(8'h00, 1'b0, 1'b1);
      want = (k == 1 || k == 2 || k == 4 || k == 6);
      checks++; if (cmdValid !== want || (want && cmdCode !== 8'h09)) begin
        errors++; $display("FAIL autorep_frame%0d got %b/%h want %b/09", k, cmdValid, cmdCode, want); end
      cyc(8'h00, 1'b0, 1'b0); cyc(8'h00, 1'b0, 1'b0);
    end
    cyc(8'hE0, 1'b1, 1'b0); cyc(8'hF0, 1'b1, 1'b0); cyc(8'h6B, 1'b1, 1'b0);
    do_reset();
  endtask
`endif

  task automatic test_random();
    logic [7:0] pool [18];
    logic [7:0] code;
    logic v, f;
    pool = '{8'hF0, 8'hE0, 8'h45, 8'h16, 8'h1E, 8'h26, 8'h2D, 8'h34, 8'h32,
             8'h79, 8'h7B, 8'h2B, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h1C, 8'h00};
    do_reset();
    for (int n = 0; n < 400; n++) begin
      code = pool[$urandom_range(17, 0)];
`ifdef CMD_AUTOREPEAT_EN
      if (code == 8'hE0) code = 8'h1C;
`endif
      v = ($urandom_range(2, 0) != 0);
      f = ($urandom_range(3, 0) == 0);
      cyc(code, v, f);
      checks++; if (cmdValid !== exp_valid || cmdCode !== exp_code) begin
        errors++; $display("FAIL rand_cmd n=%0d got %b/%h want %b/%h", n, cmdValid, cmdCode,
                           exp_valid, exp_code); end
      checks++; if (qCount !== 3'(exp_q.size()) || overflow !== exp_ovf) begin
        errors++; $display("FAIL rand_q n=%0d got %0d/%b want %0d/%b", n, qCount, overflow,
                           exp_q.size(), exp_ovf); end
    end
  endtask

  initial begin
    mk[8'h45] = 0;  mk[8'h16] = 1;  mk[8'h1E] = 2;  mk[8'h26] = 3;  mk[8'h2D] = 4;
    mk[8'h34] = 5;  mk[8'h32] = 6;  mk[8'h79] = 11; mk[8'h7B] = 12; mk[8'h2B] = 13;
    mk[256 + 8'h75] = 7; mk[256 + 8'h72] = 8; mk[256 + 8'h6B] = 9; mk[256 + 8'h74] = 10;
    test_reset();
    test_single_make();
    test_ext_break();
    test_overflow();
    test_push_pop_full();
    test_reset_mid();
    test_typematic();
`ifdef CMD_AUTOREPEAT_EN
    test_autorepeat();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_cmd_scheduler.md
PS2_CMD_SCHEDULER -- requirements
Module: ps2_cmd_scheduler

Interface
REQ-001 SHALL have parameter REPEAT_FRAMES, default 15: frames between auto-repeat commands (used only with CMD_AUTOREPEAT_EN).
REQ-002 SHALL have parameter IDLE_CODE, default 8'hFF: value on cmdCode when no command is issued.
REQ-003 clock  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state.
REQ-005 scanCode  input  8  PS/2 set-2 byte; valid only when scanValid=1.
REQ-006 scanValid  input  1  single-cycle strobe, one received byte.
REQ-007 frameStart  input  1  single-cycle pulse at start of vertical blank.
REQ-008 cmdCode  output  8  command to the display-parameter decoder; IDLE_CODE otherwise.
REQ-009 cmdValid  output  1  high for exactly the cycle in which cmdCode is not IDLE_CODE.
REQ-010 overflow  output  1  sticky; set when a command is dropped because the queue is full.
REQ-011 qCount  output  3  current queue occupancy, 0..4.

Function
REQ-012 Parser FSM states: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0); advances only on scanValid.
REQ-013 Transitions: IDLE: F0->BRK, E0->EXT, other->make(byte), stay IDLE.
REQ-014 Transitions: EXT: F0->EXT_BRK, other->extended make(byte), then IDLE.
REQ-015 Transitions: BRK and EXT_BRK: any byte->break(byte or extended byte), then IDLE.
REQ-016 Make map, non-extended: 45->0, 16->1, 1E->2, 26->3, 2D->4, 34->5, 32->6, 79->B, 7B->C, 2B->D.
REQ-017 Make map, extended: 75->7, 72->8, 6B->9, 74->A; all other makes, and all breaks, SHALL NOT enqueue.
REQ-018 A mapped make SHALL push its 4-bit command, zero-extended to 8 bits, into a 4-entry FIFO on the cycle after the final byte's scanValid.
REQ-019 On frameStart with qCount>0, the FIFO head SHALL be popped and driven on cmdCode/cmdValid for exactly one cycle, the cycle after frameStart.
REQ-020 At most one command SHALL issue per frameStart.
REQ-021 On frameStart with qCount=0, cmdCode SHALL stay IDLE_CODE.
REQ-022 On push with qCount=4 and no simultaneous pop: command dropped, overflow set, contents unchanged.
REQ-023 On simultaneous push and pop: both occur; qCount unchanged; holds even when full, with no overflow.
REQ-024 FIFO order SHALL be strict FIFO; pointers wrap modulo 4.
REQ-025 A typematic repeat (same make received again without a break) SHALL enqueue like a fresh make.

Reset
REQ-026 While reset is high: FSM=IDLE, FIFO empty, qCount=0, cmdCode=IDLE_CODE, cmdValid=0, overflow=0, and all repeat state cleared.
REQ-027 Reset asserted mid-sequence (for example after E0) SHALL discard the partial sequence; a following 75 alone SHALL be treated as non-extended and ignored.

Configuration
REQ-028 Macro CMD_AUTOREPEAT_EN SHALL, when defined, track the most recent held direction key (cmd 7..A), set by its make and cleared by its break.
REQ-029 With CMD_AUTOREPEAT_EN defined, every REPEAT_FRAMES frameStarts while a direction key is held, its command SHALL be enqueued, subject to the overflow rules.
REQ-030 With CMD_AUTOREPEAT_EN undefined, no held-key state or frame counter SHALL exist; only received makes enqueue.

Verification
REQ-031 Bytes 2D, then one frameStart -> cmdCode=04, cmdValid=1 for one cycle, one cycle after frameStart.
REQ-032 Bytes E0 75, E0 F0 75, then two frameStarts -> one cmd 07 on the first frame, IDLE_CODE on the second.
REQ-033 Five makes 16,1E,26,34,32 with no frameStart -> overflow=1, qCount=4; four frames issue 01,02,03,05.
REQ-034 With qCount=4, scanValid completing 2B in the same cycle as frameStart -> head pops, 0D enqueued, overflow stays 0.
REQ-035 Bytes E0 then reset pulse, then 6B -> nothing enqueued, qCount=0.
REQ-036 With CMD_AUTOREPEAT_EN defined and REPEAT_FRAMES=2, E0 6B held for 6 frames -> 09 issued on frames 1, 2, 4 and 6.
